// File: rtl/csa_mul_sequencer_if.sv
// csa_mul_sequencer_if: request/result bundle for the carry-save MUL sequencer.
//   master (ALU side): drives start, signed_op, multiplicand, multiplier
//   slave  (sequencer): drives busy, done, product_hi, product_lo
interface csa_mul_sequencer_if #(parameter int WIDTH = 32);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product_hi;
   logic [WIDTH-1:0] product_lo;
   modport master (output start, signed_op, multiplicand, multiplier,
                   input  busy, done, product_hi, product_lo);
   modport slave  (input  start, signed_op, multiplicand, multiplier,
                   output busy, done, product_hi, product_lo);
endinterface

// File: rtl/csa_mul_sequencer.sv
// csa_mul_sequencer: multi-cycle multiplier using a shared 7:3 carry-save reducer.
//   clk   rising-edge clock
//   clr_n asynchronous active-low reset
//   m     slave side of csa_mul_sequencer_if (start/operands in, busy/done/product out)
module csa_mul_sequencer #(
   parameter int WIDTH        = 32,
   parameter int PP_PER_CYCLE = 4
) (
   input logic                clk,
   input logic                clr_n,
   csa_mul_sequencer_if.slave m
);
   localparam int W2     = 2 * WIDTH;
   localparam int GROUPS = WIDTH / PP_PER_CYCLE;
   localparam int KW     = $clog2(GROUPS + 1);

   if (PP_PER_CYCLE < 1 || PP_PER_CYCLE > 4 || WIDTH % PP_PER_CYCLE != 0) begin : g_bad_params
      $error("csa_mul_sequencer: illegal WIDTH/PP_PER_CYCLE");
   end

   typedef enum logic [2:0] {IDLE, PREP, REDUCE, FINAL, DONE} state_t;

   state_t          state;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic            sgn, neg;
   logic [W2-1:0]   a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [W2-1:0]   s, c1, c2;
   logic [KW-1:0]   k;

   logic [W2-1:0]   rows [7];
   logic [W2-1:0]   s_n, c1_w, c2_w, c1_n, c2_n, pp_sum, sum3, prod;
   logic [2:0]      cnt;

   // a_sh/b_sh walk across the operands so each REDUCE cycle sees the next
   // group of multiplier bits at b_sh[0 +: PP_PER_CYCLE] with a_sh pre-shifted.
   always_comb begin
      rows[0] = s;
      rows[1] = c1;
      rows[2] = c2;
      for (int r = 3; r < 7; r++) rows[r] = '0;
      for (int p = 0; p < PP_PER_CYCLE; p++) rows[3+p] = b_sh[p] ? a_sh << p : '0;
      s_n    = '0;
      c1_w   = '0;
      c2_w   = '0;
      pp_sum = '0;
      cnt    = '0;
      for (int i = 0; i < W2; i++) begin
         cnt = '0;
         for (int r = 0; r < 7; r++) cnt = cnt + {2'b0, rows[i < 0 ? 0 : r][i]};
         s_n[i]  = cnt[0];
         c1_w[i] = cnt[1];
         c2_w[i] = cnt[2];
      end
      c1_n = c1_w << 1;
      c2_n = c2_w << 2;
      for (int r = 3; r < 7; r++) pp_sum = pp_sum + rows[r];
      sum3 = s + c1 + c2;
      prod = neg ? -sum3 : sum3;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state        <= IDLE;
         a_reg        <= '0;
         b_reg        <= '0;
         sgn          <= 1'b0;
         neg          <= 1'b0;
         a_sh         <= '0;
         b_sh         <= '0;
         s            <= '0;
         c1           <= '0;
         c2           <= '0;
         k            <= '0;
         m.busy       <= 1'b0;
         m.done       <= 1'b0;
         m.product_hi <= '0;
         m.product_lo <= '0;
      end else begin
         case (state)
            // DONE also accepts a new request so back-to-back ops lose no cycle
            IDLE, DONE: begin
               m.done <= 1'b0;
               m.busy <= m.start;
               state  <= m.start ? PREP : IDLE;
               if (m.start) begin
                  a_reg <= m.multiplicand;
                  b_reg <= m.multiplier;
                  sgn   <= m.signed_op;
               end
            end
            PREP: begin
               a_sh  <= {{WIDTH{1'b0}}, (sgn & a_reg[WIDTH-1]) ? -a_reg : a_reg};
               b_sh  <= (sgn & b_reg[WIDTH-1]) ? -b_reg : b_reg;
               neg   <= sgn & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
               s     <= '0;
               c1    <= '0;
               c2    <= '0;
               k     <= '0;
               state <= REDUCE;
            end
            REDUCE: begin
               s     <= s_n;
               c1    <= c1_n;
               c2    <= c2_n;
               a_sh  <= a_sh << PP_PER_CYCLE;
               b_sh  <= b_sh >> PP_PER_CYCLE;
               k     <= k + 1'b1;
               state <= (k == KW'(GROUPS - 1)) ? FINAL : REDUCE;
            end
            FINAL: begin
               {m.product_hi, m.product_lo} <= prod;
               m.done <= 1'b1;
               state  <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The reducer must conserve the row sum, so S+C1+C2 tracks the partial products taken so far.
   a_csa_conserve: assert property (@(posedge clk) disable iff (!clr_n)
      (state == REDUCE) |-> (s_n + c1_n + c2_n == s + c1 + c2 + pp_sum));
endmodule

// File: tb/tb_csa_mul_sequencer.sv
// tb_csa_mul_sequencer: directed and random checks of the carry-save MUL sequencer.
module tb_csa_mul_sequencer;
   logic clk = 1'b0;
   logic clr_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   csa_mul_sequencer_if #(.WIDTH(32)) bus ();

   csa_mul_sequencer #(.WIDTH(32), .PP_PER_CYCLE(4)) dut (
      .clk  (clk),
      .clr_n(clr_n),
      .m    (bus)
   );

   // Launch one op and wait for done; lat is edges from the start edge, -1 on timeout.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sop,
                         output logic [63:0] p, output int lat);
      @(negedge clk);
      bus.start        = 1'b1;
      bus.signed_op    = sop;
      bus.multiplicand = a;
      bus.multiplier   = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = -1;
      p   = '0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = i;
            p   = {bus.product_hi, bus.product_lo};
            break;
         end
      end
   endtask

   task automatic test_reset;
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
      n_cmp++; if (bus.product_hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", bus.product_hi); end
      n_cmp++; if (bus.product_lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", bus.product_lo); end
      @(negedge clk);
      clr_n = 1'b1;
   endtask

   task automatic test_unsigned_small;
      logic [63:0] p;
      @(negedge clk);
      bus.start = 1'b1; bus.signed_op = 1'b0; bus.multiplicand = 32'd3; bus.multiplier = 32'd5;
      for (int e = 0; e <= 11; e++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (e <= 10) begin
            n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL small_busy edge %0d got %b want 1", e, bus.busy); end
         end else begin
            n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL small_idle edge %0d got %b want 0", e, bus.busy); end
         end
         n_cmp++; if (bus.done !== (e == 10)) begin n_bad++; $display("FAIL small_done edge %0d got %b want %b", e, bus.done, e == 10); end
         if (e == 10) p = {bus.product_hi, bus.product_lo};
      end
      n_cmp++; if (p !== 64'h0000_0000_0000_000F) begin n_bad++; $display("FAIL small_prod got %h want 000000000000000f", p); end
   endtask

   task automatic test_extremes;
      logic [31:0] av [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000};
      logic [31:0] bv [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0006, 32'h8000_0000};
      logic        sv [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic [63:0] ev [4] = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001,
                              64'hFFFF_FFFF_FFFF_FFD6, 64'h4000_0000_0000_0000};
      logic [63:0] p;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         run_op(av[i], bv[i], sv[i], p, lat);
         n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL extreme%0d_latency got %0d want 10", i, lat); end
         n_cmp++; if (p !== ev[i]) begin n_bad++; $display("FAIL extreme%0d_prod got %h want %h", i, p, ev[i]); end
      end
   endtask

   task automatic test_back_to_back;
      int          dones = 0;
      logic [63:0] p = '0;
      int          lat = -1;
      @(negedge clk);
      bus.start = 1'b1; bus.signed_op = 1'b0; bus.multiplicand = 32'd100; bus.multiplier = 32'd3;
      for (int e = 0; e <= 11; e++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin dones++; p = {bus.product_hi, bus.product_lo}; end
         if (e == 11) bus.start = 1'b0;
         else begin
            bus.multiplicand = 32'd101 + 32'(e);
            bus.multiplier   = 32'd4 + 32'(e);
         end
      end
      n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL held_done_count got %0d want 1", dones); end
      n_cmp++; if (p !== 64'd300) begin n_bad++; $display("FAIL held_prod got %0d want 300", p); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL second_accept_busy got %b want 1", bus.busy); end
      for (int e = 12; e <= 30; e++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin lat = e; p = {bus.product_hi, bus.product_lo}; break; end
      end
      n_cmp++; if (lat !== 21) begin n_bad++; $display("FAIL second_done_edge got %0d want 21", lat); end
      n_cmp++; if (p !== 64'd1554) begin n_bad++; $display("FAIL second_prod got %0d want 1554", p); end
   endtask

   task automatic test_reset_mid;
      int          dones = 0;
      logic [63:0] p;
      int          lat;
      @(negedge clk);
      bus.start = 1'b1; bus.signed_op = 1'b0; bus.multiplicand = 32'd5; bus.multiplier = 32'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      clr_n = 1'b0;
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.product_lo !== 32'h0) begin n_bad++; $display("FAIL midrst_lo got %h want 0", bus.product_lo); end
      n_cmp++; if (bus.product_hi !== 32'h0) begin n_bad++; $display("FAIL midrst_hi got %h want 0", bus.product_hi); end
      @(negedge clk);
      clr_n = 1'b1;
      for (int e = 0; e < 15; e++) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midrst_no_done got %0d want 0", dones); end
      run_op(32'h1234, 32'h10, 1'b0, p, lat);
      n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL fresh_latency got %0d want 10", lat); end
      n_cmp++; if (p !== 64'h0000_0000_0001_2340) begin n_bad++; $display("FAIL fresh_prod got %h want 0000000000012340", p); end
   endtask

   task automatic test_random;
      logic [31:0] a, b;
      logic        sop;
      logic [63:0] p, e;
      int          lat;
      for (int i = 0; i < 256; i++) begin
         a   = $urandom;
         b   = $urandom;
         sop = 1'($urandom_range(0, 1));
         if (i % 16 == 0) a = 32'h8000_0000;
         if (i % 16 == 1) b = 32'hFFFF_FFFF;
         e = sop ? 64'(longint'($signed(a)) * longint'($signed(b))) : {32'b0, a} * {32'b0, b};
         run_op(a, b, sop, p, lat);
         n_cmp++; if (p !== e || lat !== 10) begin
            n_bad++; $display("FAIL random%0d a=%h b=%h s=%b got %h lat %0d want %h lat 10", i, a, b, sop, p, lat, e);
         end
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.signed_op = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
      test_reset;
      test_unsigned_small;
      test_extremes;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
